// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART byte transmitter among NUM_REQ sources.
// Grants are held for a whole packet; granted bytes pass through a one-entry output register.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MAX_PKT_LEN = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       trunc_err
);

    localparam int unsigned GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   cand;
    logic            found;
    logic            can_take;
    logic            accept;
    logic            hit_max;
    logic            drain_done;
    logic [7:0]      cur_data;
    logic [7:0]      byte_cnt;
    logic [7:0]      cnt_inc;

    // First valid requester after last_grant, wrapping modulo NUM_REQ.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((32'(last_grant) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign cur_data   = req_data[{grant_id, 3'b000} +: 8];
    assign cnt_inc    = byte_cnt + 8'd1;
    assign drain_done = !tx_valid || tx_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        can_take   = 1'b0;
        accept     = 1'b0;
        hit_max    = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                can_take            = !tx_valid || tx_ready;
                req_ready[grant_id] = can_take;
                accept              = can_take && req_valid[grant_id];
                if (accept) begin
                    if (req_last[grant_id]) begin
                        state_next = DRAIN;
                    end else if (cnt_inc == 8'(MAX_PKT_LEN)) begin
                        hit_max    = 1'b1;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            byte_cnt   <= '0;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            trunc_err  <= 1'b0;
        end else begin
            trunc_err <= hit_max;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        byte_cnt <= '0;
                    end
                end
                XFER: begin
                    // A new byte may land in the same cycle the old one leaves.
                    if (accept) begin
                        tx_data  <= cur_data;
                        tx_valid <= 1'b1;
                        byte_cnt <= cnt_inc;
                    end else if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        tx_valid   <= 1'b0;
                        last_grant <= grant_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle behavioural model compare,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned MAXL = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*8-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready = 1'b1;
    logic [1:0]        grant_id;
    logic              busy;
    logic              trunc_err;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .MAX_PKT_LEN(MAXL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .trunc_err (trunc_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Source streams: {last, data} per byte, one queue per requester.
    logic [8:0]      srcq [NREQ][$];
    bit [NREQ-1:0]   hold = '0;
    bit [NREQ-1:0]   hs_seen = '0;
    bit              rand_mode = 1'b0;
    int              txr_mode = 0;
    int              pat_idx = 0;

    int              cyc = 0;
    int              last_acc_cyc = 0;
    int              busy_fall_cyc = 0;
    int              trunc_cnt = 0;
    int              stall_ready = 0;
    int              sent = 0;
    int              pushed = 0;
    logic            prev_busy = 1'b0;
    int              grant_log[$];
    int              tx_cyc[$];
    logic [7:0]      tx_log[$];
    logic [NREQ-1:0] exp_ready;

    // Reference model: who owns the transmitter, whether the packet is closing,
    // and the single buffered byte.
    int         m_owner = -1;
    int         m_last = NREQ - 1;
    int         m_gid = 0;
    int         m_cnt = 0;
    bit         m_closing = 1'b0;
    bit         m_txv = 1'b0;
    bit         m_trunc = 1'b0;
    bit         m_init = 1'b0;
    logic [7:0] m_txd = '0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_owner = -1; m_closing = 1'b0; m_txv = 1'b0; m_txd = '0;
            m_gid = 0; m_last = NREQ - 1; m_trunc = 1'b0; m_cnt = 0; m_init = 1'b1;
            return;
        end
        m_trunc = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                int c = (m_last + k) % int'(NREQ);
                if (req_valid[c]) begin
                    m_owner = c; m_gid = c; m_cnt = 0;
                    break;
                end
            end
        end else if (!m_closing) begin
            bit room = !m_txv || tx_ready;
            if (room && req_valid[m_owner]) begin
                m_txd = req_data[m_owner*8 +: 8];
                m_txv = 1'b1;
                m_cnt++;
                if (req_last[m_owner]) begin
                    m_closing = 1'b1;
                end else if (m_cnt == int'(MAXL)) begin
                    m_closing = 1'b1;
                    m_trunc = 1'b1;
                end
            end else if (m_txv && tx_ready) begin
                m_txv = 1'b0;
            end
        end else if (!m_txv || tx_ready) begin
            m_txv = 1'b0; m_last = m_owner; m_owner = -1; m_closing = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (m_init) begin
            exp_ready = '0;
            if (m_owner >= 0 && !m_closing && (!m_txv || tx_ready)) exp_ready[m_owner] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            check("tx_valid", tx_valid, m_txv);
            check("tx_data", tx_data, m_txd);
            check("grant_id", grant_id, m_gid);
            check("busy", busy, m_owner >= 0);
            check("trunc_err", trunc_err, m_trunc);
        end
        hs_seen = req_valid & req_ready;
        if (|(hs_seen & req_last)) last_acc_cyc = cyc;
        if (tx_valid && tx_ready) begin
            tx_log.push_back(tx_data);
            tx_cyc.push_back(cyc);
            sent++;
        end
        if (tx_valid && !tx_ready && |req_ready) stall_ready++;
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        if (!busy && prev_busy) busy_fall_cyc = cyc;
        if (trunc_err) trunc_cnt++;
        prev_busy = busy;
        model_step();
    end

    task automatic drive();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_valid[i] = (srcq[i].size() > 0) && !hold[i];
            if (srcq[i].size() > 0) {req_last[i], req_data[i*8 +: 8]} = srcq[i][0];
            else {req_last[i], req_data[i*8 +: 8]} = '0;
        end
    endtask

    task automatic tick();
        logic [8:0] dump;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NREQ); i++)
            if (hs_seen[i] && srcq[i].size() > 0) dump = srcq[i].pop_front();
        case (txr_mode)
            0: tx_ready = 1'b1;
            1: begin tx_ready = (pat_idx % 3 == 0); pat_idx++; end
            default: tx_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (rand_mode)
            for (int i = 0; i < int'(NREQ); i++) hold[i] = ($urandom_range(0, 4) == 0);
        drive();
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input bit lst);
        srcq[r].push_back({lst, d});
        pushed++;
        drive();
    endtask

    task automatic push_pkt(input int r, input int len, input int base, input bit term);
        for (int b = 0; b < len; b++) push_byte(r, 8'(base + b), term && (b == len - 1));
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < int'(NREQ); i++) if (srcq[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_done(input string name, input int max_cyc);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < max_cyc) begin
            tick();
            n++;
            done = !busy && !tx_valid && all_empty();
        end
        check({"timeout_", name}, done, 1);
        repeat (2) tick();
    endtask

    task automatic wait_size(input int r, input int sz, input int max_cyc);
        int n = 0;
        while (srcq[r].size() > sz && n < max_cyc) begin
            tick();
            n++;
        end
        check("timeout_wait_size", srcq[r].size() <= sz, 1);
    endtask

    task automatic clear_logs();
        grant_log.delete(); tx_log.delete(); tx_cyc.delete();
        trunc_cnt = 0; stall_ready = 0;
    endtask

    task automatic check_tx(input string name, input logic [7:0] exp[$]);
        check({name, "_count"}, tx_log.size(), exp.size());
        for (int k = 0; k < exp.size(); k++)
            if (k < tx_log.size()) check({name, "_byte"}, tx_log[k], exp[k]);
    endtask

    task automatic check_grants(input string name, input int exp[$]);
        check({name, "_ngrants"}, grant_log.size(), exp.size());
        for (int k = 0; k < exp.size(); k++)
            if (k < grant_log.size()) check({name, "_grant"}, grant_log[k], exp[k]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] eb[$];
        int eg[$];
        int r;
        drive();
        repeat (3) tick();
        rst_n = 1'b1;

        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_trunc_err", trunc_err, 0);

        // Fairness: four requesters, two 2-byte packets each.
        clear_logs();
        for (int p = 0; p < 2; p++)
            for (int q = 0; q < int'(NREQ); q++) push_pkt(q, 2, q * 16 + p * 2, 1'b1);
        run_until_done("fair", 200);
        eg = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_grants("fair", eg);
        eb.delete();
        for (int k = 0; k < 16; k++) eb.push_back(8'(((k / 2) % 4) * 16 + ((k / 2) / 4) * 2 + k % 2));
        check_tx("fair", eb);

        // Single packet from requester 2.
        clear_logs();
        push_byte(2, 8'h41, 1'b0);
        push_byte(2, 8'h42, 1'b0);
        push_byte(2, 8'h0A, 1'b1);
        run_until_done("single", 50);
        eg = '{2};
        check_grants("single", eg);
        eb = '{8'h41, 8'h42, 8'h0A};
        check_tx("single", eb);
        if (tx_cyc.size() == 3) check("single_consecutive", tx_cyc[2] - tx_cyc[0], 2);
        check("single_busy_fall", busy_fall_cyc - last_acc_cyc, 2);

        // Valid gap: requester 3 stalls mid-packet while requester 0 waits.
        clear_logs();
        push_pkt(3, 2, 8'h30, 1'b0);
        push_pkt(0, 2, 8'h05, 1'b1);
        wait_size(3, 0, 50);
        repeat (5) begin
            tick();
            check("gap_grant", grant_id, 3);
            check("gap_busy", busy, 1);
            check("gap_ready0", req_ready[0], 0);
        end
        push_pkt(3, 2, 8'h32, 1'b1);
        run_until_done("gap", 100);
        eg = '{3, 0};
        check_grants("gap", eg);
        eb = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h05, 8'h06};
        check_tx("gap", eb);

        // Backpressure: tx_ready pattern 1,0,0 repeating.
        clear_logs();
        txr_mode = 1;
        pat_idx = 0;
        push_pkt(0, 4, 8'hA0, 1'b1);
        run_until_done("bp", 100);
        txr_mode = 0;
        eg = '{0};
        check_grants("bp", eg);
        eb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        check_tx("bp", eb);
        check("bp_ready_while_full", stall_ready, 0);

        // Truncation at MAXL=4 with requester 2 waiting.
        clear_logs();
        push_pkt(1, 6, 8'h10, 1'b1);
        push_pkt(2, 1, 8'h20, 1'b1);
        run_until_done("trunc", 100);
        check("trunc_pulses", trunc_cnt, 1);
        eg = '{1, 2, 1};
        check_grants("trunc", eg);
        eb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h14, 8'h15};
        check_tx("trunc", eb);

        // Reset in the middle of a packet.
        clear_logs();
        push_pkt(2, 4, 8'h50, 1'b1);
        wait_size(2, 2, 50);
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < int'(NREQ); i++) srcq[i].delete();
        drive();
        check("mid_rst_grant_id", grant_id, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_req_ready", req_ready, 0);
        rst_n = 1'b1;
        clear_logs();
        push_pkt(3, 1, 8'h60, 1'b1);
        push_pkt(0, 1, 8'h70, 1'b1);
        run_until_done("post_rst", 50);
        eg = '{0, 3};
        check_grants("post_rst", eg);
        eb = '{8'h70, 8'h60};
        check_tx("post_rst", eb);

        // Randomized traffic, then drain and check byte conservation.
        clear_logs();
        sent = 0;
        pushed = 0;
        rand_mode = 1'b1;
        txr_mode = 2;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, NREQ - 1));
                if (srcq[r].size() < 12)
                    push_pkt(r, int'($urandom_range(1, 6)), int'($urandom_range(0, 255)), 1'b1);
            end
            tick();
        end
        rand_mode = 1'b0;
        hold = '0;
        txr_mode = 0;
        drive();
        run_until_done("rand_drain", 500);
        check("rand_bytes", sent, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
